// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the data-memory arbiter.
// Read-response owner encoding and default bus widths.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DBG and memory-side signals of the data-memory arbiter.
// slave: arbiter view; master: LSU/DBG/memory environment view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [3:0]        dbg_be;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be,
    input  cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_be,
    input  dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be,
    output cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_be,
    output dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating DBG wait counter; at_max flags a starved DBG.
// Only built when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_ctr #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt;

  // clear wins; otherwise count up and stick at MAX
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAXV) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max = (cnt == MAXV);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DBG arbiter and read-response router for the data BRAM.
// DMEM_ARB_STARVE_EN: bound DBG starvation with a wait counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  logic   force_dbg;
  logic   cpu_gnt;
  logic   dbg_gnt;
  owner_t resp_own;
  owner_t own_nxt;

  logic [3:0]        we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

`ifdef DMEM_ARB_STARVE_EN
  logic at_max;

  dmem_arb_starve_ctr #(
    .MAX (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.dbg_req & ~dbg_gnt),
    .clr     (~bus.dbg_req | dbg_gnt),
    .at_max  (at_max)
  );

  assign force_dbg = at_max & bus.dbg_req;
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign force_dbg = 1'b0;
`endif

  assign cpu_gnt = reset_n & bus.cpu_req
                 & ~force_dbg;
  assign dbg_gnt = reset_n & bus.dbg_req
                 & (force_dbg | ~bus.cpu_req);

  // steer the granted master onto the memory port
  always_comb begin
    we_sel    = 4'b0000;
    addr_sel  = bus.cpu_addr;
    wdata_sel = bus.cpu_wdata;
    unique case (1'b1)
      cpu_gnt: begin
        we_sel = bus.cpu_we ? bus.cpu_be
                            : 4'b0000;
      end
      dbg_gnt: begin
        we_sel    = bus.dbg_we ? bus.dbg_be
                               : 4'b0000;
        addr_sel  = bus.dbg_addr;
        wdata_sel = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  // owner of the read returning next cycle
  always_comb begin
    own_nxt = OWN_NONE;
    unique case (1'b1)
      cpu_gnt: begin
        if (!bus.cpu_we) own_nxt = OWN_CPU;
      end
      dbg_gnt: begin
        if (!bus.dbg_we) own_nxt = OWN_DBG;
      end
      default: ;
    endcase
  end

  // response owner register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_own <= OWN_NONE;
    end else begin
      resp_own <= own_nxt;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  // a read in flight when reset hits is dropped
  assign bus.cpu_rvalid = reset_n
                        & (resp_own == OWN_CPU);
  assign bus.dbg_rvalid = reset_n
                        & (resp_own == OWN_DBG);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, starvation and reset runs.
// Read responses are checked against a queue of expected results.
module tb_dmem_arbiter;

  import dmem_arb_pkg::*;

  typedef struct {
    logic        cr;
    logic        cw;
    logic [3:0]  cb;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        dr;
    logic        dw;
    logic [3:0]  db;
    logic [9:0]  da;
    logic [31:0] dd;
    logic        gc;
    logic        gd;
    logic [3:0]  ewe;
  } vec_t;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int total = 0;
  int bad = 0;

  rsp_t sb[$];
  logic [31:0] ram [0:1023];
  logic [31:0] shadow [0:1023];
  vec_t tbl [18];

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (32),
    .MAX_WAIT (8)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // behavioural BRAM: 1-cycle read, byte-lane writes
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.mem_we[l])
        ram[bus.mem_addr][8*l +: 8] <=
          bus.mem_wdata[8*l +: 8];
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic cr, input logic cw,
    input logic [3:0] cb, input logic [9:0] ca,
    input logic [31:0] cd,
    input logic dr, input logic dw,
    input logic [3:0] db, input logic [9:0] da,
    input logic [31:0] dd,
    input logic gc, input logic gd,
    input logic [3:0] ewe);
    vec_t v;
    v.cr = cr; v.cw = cw; v.cb = cb;
    v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.db = db;
    v.da = da; v.dd = dd;
    v.gc = gc; v.gd = gd; v.ewe = ewe;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.cpu_req   = v.cr;
    bus.cpu_we    = v.cw;
    bus.cpu_be    = v.cb;
    bus.cpu_addr  = v.ca;
    bus.cpu_wdata = v.cd;
    bus.dbg_req   = v.dr;
    bus.dbg_we    = v.dw;
    bus.dbg_be    = v.db;
    bus.dbg_addr  = v.da;
    bus.dbg_wdata = v.dd;
  endtask

  task automatic chk_rsp(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.sb act=empty exp=entry",
               tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".cvld"}, bus.cpu_rvalid,
          32'(e.own == 2'd1));
      chk({tag, ".dvld"}, bus.dbg_rvalid,
          32'(e.own == 2'd2));
      if (e.own == 2'd1)
        chk({tag, ".crd"}, bus.cpu_rdata, e.data);
      if (e.own == 2'd2)
        chk({tag, ".drd"}, bus.dbg_rdata, e.data);
    end
  endtask

  task automatic step(input vec_t v,
                      input string tag);
    rsp_t n;
    logic w;
    logic [3:0] be;
    logic [9:0] a;
    logic [31:0] d;
    drive(v);
    @(negedge clk);
    chk({tag, ".cgnt"}, bus.cpu_gnt, v.gc);
    chk({tag, ".dgnt"}, bus.dbg_gnt, v.gd);
    chk({tag, ".mwe"}, bus.mem_we, v.ewe);
    chk_rsp(tag);
    w = 1'b0; be = 4'h0; a = '0; d = '0;
    if (v.gc) begin
      w = v.cw; be = v.cb; a = v.ca; d = v.cd;
    end else if (v.gd) begin
      w = v.dw; be = v.db; a = v.da; d = v.dd;
    end
    if (v.gc || v.gd) begin
      chk({tag, ".madr"}, bus.mem_addr, a);
      if (w) chk({tag, ".mwd"}, bus.mem_wdata, d);
    end
    n.own = 2'd0;
    if (v.gc && !v.cw) n.own = 2'd1;
    if (v.gd && !v.dw) n.own = 2'd2;
    n.data = shadow[a];
    sb.push_back(n);
    if ((v.gc || v.gd) && w) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) shadow[a][8*l +: 8] = d[8*l +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    int ndbg;
    bit edbg;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    idle = mk(0,0,4'h0,10'h0,32'h0,
              0,0,4'h0,10'h0,32'h0, 0,0,4'h0);
    drive(idle);

    tbl[0]  = mk(1,1,4'hF,10'h010,32'hDEADBEEF,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'hF);
    tbl[1]  = mk(1,0,4'hF,10'h010,32'h0,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[2]  = mk(1,1,4'hF,10'h020,32'h11223344,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'hF);
    tbl[3]  = mk(1,1,4'h2,10'h020,32'h0000AB00,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h2);
    tbl[4]  = mk(1,0,4'h0,10'h020,32'h0,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[5]  = idle;
    tbl[6]  = mk(0,0,4'h0,10'h000,32'h0,
                 1,1,4'hF,10'h030,32'hCAFEF00D,
                 0,1,4'hF);
    tbl[7]  = mk(1,0,4'h0,10'h010,32'h0,
                 1,0,4'h0,10'h030,32'h0, 1,0,4'h0);
    tbl[8]  = mk(0,0,4'h0,10'h000,32'h0,
                 1,0,4'h0,10'h030,32'h0, 0,1,4'h0);
    tbl[9]  = mk(1,0,4'h0,10'h020,32'h0,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[10] = mk(0,0,4'h0,10'h000,32'h0,
                 1,0,4'h0,10'h010,32'h0, 0,1,4'h0);
    tbl[11] = mk(1,0,4'h0,10'h030,32'h0,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[12] = mk(0,0,4'h0,10'h000,32'h0,
                 1,0,4'h0,10'h020,32'h0, 0,1,4'h0);
    tbl[13] = mk(1,1,4'h0,10'h010,32'hFFFFFFFF,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[14] = mk(1,0,4'h0,10'h010,32'h0,
                 0,0,4'h0,10'h000,32'h0, 1,0,4'h0);
    tbl[15] = mk(0,0,4'h0,10'h000,32'h0,
                 1,1,4'h8,10'h040,32'h12000000,
                 0,1,4'h8);
    tbl[16] = mk(0,0,4'h0,10'h000,32'h0,
                 1,0,4'h0,10'h040,32'h0, 0,1,4'h0);
    tbl[17] = idle;

    // reset state with requests pending
    bus.cpu_req = 1'b1;
    bus.dbg_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst.cgnt", bus.cpu_gnt, 0);
      chk("rst.dgnt", bus.dbg_gnt, 0);
      chk("rst.mwe", bus.mem_we, 0);
      chk("rst.cvld", bus.cpu_rvalid, 0);
      chk("rst.dvld", bus.dbg_rvalid, 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.push_back('{own: 2'd0, data: 32'h0});

    for (int i = 0; i < 18; i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // both masters request every cycle
    ndbg = 0;
    for (int k = 0; k < 27; k++) begin
`ifdef DMEM_ARB_STARVE_EN
      edbg = ((k % 9) == 8);
`else
      edbg = 1'b0;
`endif
      v = mk(1,0,4'h0,10'h010,32'h0,
             1,0,4'h0,10'h030,32'h0,
             !edbg, edbg, 4'h0);
      if (bus.dbg_gnt) ndbg++;
      step(v, $sformatf("stv%0d", k));
    end
    step(idle, "stv_end");

    // reset lands the cycle after a CPU read grant
    step(mk(1,0,4'h0,10'h020,32'h0,
            0,0,4'h0,10'h000,32'h0, 1,0,4'h0),
         "prerst");
    reset_n = 1'b0;
    drive(mk(1,1,4'hF,10'h050,32'h55555555,
             1,0,4'h0,10'h030,32'h0, 0,0,4'h0));
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mrst.cgnt", bus.cpu_gnt, 0);
      chk("mrst.dgnt", bus.dbg_gnt, 0);
      chk("mrst.mwe", bus.mem_we, 0);
      chk("mrst.cvld", bus.cpu_rvalid, 0);
      chk("mrst.dvld", bus.dbg_rvalid, 0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    sb.push_back('{own: 2'd0, data: 32'h0});
    step(mk(1,1,4'hF,10'h050,32'h55555555,
            0,0,4'h0,10'h000,32'h0, 1,0,4'hF),
         "post0");
    step(mk(1,0,4'h0,10'h050,32'h0,
            0,0,4'h0,10'h000,32'h0, 1,0,4'h0),
         "post1");
    step(idle, "post2");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer placed in front of the data-memory wrapper, which is a single-port block RAM with 1-cycle synchronous read and 4-bit byte-lane write enables. It shares the memory between the core's load/store unit (CPU port) and a debug/DMA master (DBG port). Each cycle it grants at most one request, drives the memory port, and routes the read data back to the owner one cycle later. The CPU port has priority, and a wait counter bounds how long DBG can be starved.

## Interface
- ADDR_W, 10, word address width; matches the data-memory depth
- DATA_W, 32, data width
- MAX_WAIT, 8, cycles DBG may wait before it is force-granted; legal range 1–255

- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  4  byte-lane enables; ignored on reads
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid; reads only
- cpu_rdata  out  DATA_W  read data
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the DBG master
- mem_we  out  4  byte write enables to memory; 0 on reads and when idle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the address

## Operation
- Grant logic is combinational from the requests, wait_cnt and reset_n. At most one of cpu_gnt and dbg_gnt is high in any cycle.
- Priority:
  - If force_dbg (wait_cnt == MAX_WAIT and dbg_req) → grant DBG.
  - Else if cpu_req → grant CPU.
  - Else if dbg_req → grant DBG.
- The memory port carries the granted master's addr and wdata. mem_we = granted_we ? granted_be : 4'b0000.
- With no grant: mem_we = 0, and mem_addr/mem_wdata hold the CPU port's values (don't-care).
- Response owner register resp_own, type owner_t, takes one of three values:
  - OWN_NONE: no read outstanding.
  - OWN_CPU: the CPU read that was granted last cycle returns now.
  - OWN_DBG: the DBG read that was granted last cycle returns now.
- resp_own transitions each cycle:
  - A granted read loads the owner.
  - A granted write or no grant loads OWN_NONE.
- Response outputs:
  - cpu_rvalid = (resp_own == OWN_CPU); dbg_rvalid = (resp_own == OWN_DBG).
  - Both rdata outputs are mem_rdata, unregistered.
  - There is no response backpressure. Masters must accept rvalid.
- Wait counter wait_cnt (width $clog2(MAX_WAIT+1)):
  - Clears when dbg_req is low or dbg_gnt is high.
  - Otherwise increments, saturating at MAX_WAIT.
- A write with be == 0 is still granted and consumes the cycle. No memory lanes change.
- A master holds req/we/be/addr/wdata stable until it sees gnt. It may issue back-to-back requests every cycle.

## Timing
- Cycle N: req high and gnt high → memory is driven in N, and the BRAM samples at the end of N.
- Cycle N+1: for a read, rvalid = 1 with rdata = mem[addr]. Load latency is 1 cycle. Throughput is 1 access per cycle.
- Write-then-read to the same address in N and N+1: the read returns the newly written data in N+2.
- Reset (reset_n low at an edge):
  - resp_own = OWN_NONE and wait_cnt = 0.
  - While reset_n is low, gnt = 0 on both ports and mem_we = 0.
  - rvalid is 0 on both ports from the first cycle after reset is sampled.
  - A read granted in the cycle before reset produces no response.
- Simultaneous CPU and DBG requests with wait_cnt < MAX_WAIT → CPU wins and DBG's wait_cnt increments.

## Configuration
- DMEM_ARB_STARVE_EN defined: the wait counter and the force_dbg rule are compiled in.
- Undefined: strict CPU priority. wait_cnt is not instantiated, force_dbg is tied to 0, and MAX_WAIT is unused. DBG can be starved indefinitely.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_DBG}
  - constants DMEM_ADDR_W = 10 and DMEM_DATA_W = 32, used as parameter defaults
- One sub-module, dmem_arb_starve_ctr: a saturating counter with inputs inc and clr, output at_max, and parameter MAX. It is instantiated only under DMEM_ARB_STARVE_EN.
- The top-level arbiter is instantiated between the LSU and the data-memory wrapper. It drives the wrapper's we with |mem_we and its byteEnable with mem_we.

## Test plan
- CPU writes 0xDEADBEEF to addr 0x010 with be=4'hF, then reads 0x010 → cpu_gnt both cycles; cpu_rvalid=1 one cycle after the read grant with rdata=0xDEADBEEF; dbg_rvalid stays 0.
- CPU writes byte be=4'b0010, data 0x0000AB00, to a word holding 0x11223344, then reads it → 0x1122AB44.
- CPU and DBG request continuously with MAX_WAIT=8 and STARVE_EN defined → DBG is granted exactly on every 9th cycle, and wait_cnt clears after each DBG grant. With STARVE_EN undefined, dbg_gnt is never asserted.
- Alternating CPU and DBG reads every cycle → each rvalid goes only to its owner, with zero dead cycles.
- reset_n driven low in the cycle after a CPU read grant → no cpu_rvalid, mem_we=0 and both gnt=0 during reset. After release, the first request is granted in the same cycle.
